// File: rtl/frameblock_pkg.sv
// Shared constants, state encoding and coordinate helper for the frameblock
// display-side scanout logic.
package frameblock_pkg;

   localparam int BLOCK_DIM   = 32;
   localparam int BLOCK_WORDS = 1024;
   localparam int ID_W        = 7;
   localparam int ADDR_W      = 10;
   localparam int PIX_W       = 16;
   localparam int HDR_WORDS   = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_PIX  = 3'd2,
      ST_NEXT = 3'd3,
      ST_HOLD = 3'd4
   } scan_state_e;

   // Pixel origin of a block column/row index on the panel.
   function automatic logic [PIX_W-1:0] block_origin(input int blk);
      return PIX_W'(blk * BLOCK_DIM);
   endfunction

endpackage

// File: rtl/frameblock_skid.sv
// Two-entry valid/ready skid buffer. The head entry drives the stream output
// directly from a register; the free-slot count lets the producer decide
// whether a read issued now can still be absorbed when its data lands.
module frameblock_skid
   import frameblock_pkg::*;
#(
   parameter int W = PIX_W + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   input  logic [W-1:0] in_data_i,
   output logic         in_ready_o,
   output logic         out_valid_o,
   output logic [W-1:0] out_data_o,
   input  logic         out_ready_i,
   output logic [1:0]   free_o
);

   logic [1:0]   occ_q, occ_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic         push_s, pop_s;

   assign out_valid_o = (occ_q != 2'd0);
   assign out_data_o  = head_q;
   assign in_ready_o  = (occ_q != 2'd2) || out_ready_i;
   assign free_o      = 2'd2 - occ_q;
   assign push_s      = in_valid_i && in_ready_o;
   assign pop_s       = out_valid_o && out_ready_i;

   // Next-state of the two entries for every push/pop combination.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case ({push_s, pop_s})
         2'b10: begin
            case (occ_q)
               2'd0: begin
                  head_d = in_data_i;
                  occ_d  = 2'd1;
               end
               2'd1: begin
                  tail_d = in_data_i;
                  occ_d  = 2'd2;
               end
               default: occ_d = occ_q;
            endcase
         end
         2'b01: begin
            case (occ_q)
               2'd2: begin
                  head_d = tail_q;
                  occ_d  = 2'd1;
               end
               2'd1: occ_d = 2'd0;
               default: occ_d = occ_q;
            endcase
         end
         2'b11: begin
            case (occ_q)
               2'd1: head_d = in_data_i;
               2'd2: begin
                  head_d = tail_q;
                  tail_d = in_data_i;
               end
               default: occ_d = occ_q;
            endcase
         end
         default: occ_d = occ_q;
      endcase
   end

   // Entry and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

endmodule

// File: rtl/frameblock_scanout.sv
// Display-side sequencer: waits for a finished block, emits its 4-word screen
// window header and 1024 pixels over a valid/ready stream, then releases the
// display buffer. Pixel reads are issued only when the skid buffer is known to
// have room when the 1-cycle-late read data arrives.
module frameblock_scanout
   import frameblock_pkg::*;
#(
   parameter int BLOCKS_X = 10,
   parameter int BLOCKS_Y = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [PIX_W-1:0]  display_rddata,
   output logic [ADDR_W-1:0] display_rdaddr,
   input  logic [ID_W-1:0]   display_id,
   input  logic              display_ready,
   output logic              display_next,
   output logic [PIX_W-1:0]  out_data,
   output logic              out_cmd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic [7:0]        skip_count
);

   localparam int NUM_BLOCKS = BLOCKS_X * BLOCKS_Y;

   scan_state_e       state_q, state_d;
   logic [1:0]        hdr_idx_q, hdr_idx_d;
   logic [PIX_W-1:0]  x0_q, x0_d, y0_q, y0_d;
   logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic              pend_q;
   logic [7:0]        skip_q, skip_d;
   logic              next_q, busy_q;

   logic              id_valid_s;
   logic [PIX_W-1:0]  x0_s, y0_s, hdr_word_s, hdr_data_s;
   logic              start_s, hdr_push_s, issue_win_s, issue_s, room_s;
   logic              push_valid_s;
   logic [PIX_W:0]    push_word_s;
   logic              skid_in_ready_s, skid_valid_s, pop_s;
   logic [PIX_W:0]    skid_out_s;
   logic [1:0]        free_s;

   assign id_valid_s = (int'(display_id) < NUM_BLOCKS);
   assign x0_s       = block_origin(int'(display_id) % BLOCKS_X);
   assign y0_s       = block_origin(int'(display_id) / BLOCKS_X);
   assign pop_s      = skid_valid_s && out_ready;

   // Header words after the first one come from the latched window origin.
   always_comb begin
      case (hdr_idx_q)
         2'd1:    hdr_word_s = x0_q + 16'd31;
         2'd2:    hdr_word_s = y0_q;
         2'd3:    hdr_word_s = y0_q + 16'd31;
         default: hdr_word_s = x0_q;
      endcase
   end

   // Scanout FSM, header sequencing, read issue and pixel handshake counting.
   always_comb begin
      state_d     = state_q;
      hdr_idx_d   = hdr_idx_q;
      x0_d        = x0_q;
      y0_d        = y0_q;
      pix_cnt_d   = pix_cnt_q;
      skip_d      = skip_q;
      start_s     = 1'b0;
      hdr_push_s  = 1'b0;
      hdr_data_s  = 16'd0;
      issue_win_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && display_ready) begin
               if (id_valid_s) begin
                  // First header word goes straight from the incoming id.
                  x0_d       = x0_s;
                  y0_d       = y0_s;
                  hdr_push_s = 1'b1;
                  hdr_data_s = x0_s;
                  hdr_idx_d  = 2'd1;
                  pix_cnt_d  = '0;
                  start_s    = 1'b1;
                  state_d    = ST_HDR;
               end else begin
                  skip_d  = skip_q + 8'd1;
                  state_d = ST_NEXT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (skid_in_ready_s) begin
               hdr_push_s = 1'b1;
               hdr_data_s = hdr_word_s;
               hdr_idx_d  = hdr_idx_q + 2'd1;
               if (hdr_idx_q == 2'(HDR_WORDS - 1)) begin
                  // Prefetch pixel 0 alongside the last header word.
                  issue_win_s = 1'b1;
                  state_d     = ST_PIX;
               end else begin
                  state_d = ST_HDR;
               end
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_PIX: begin
            issue_win_s = 1'b1;
            if (pop_s && !skid_out_s[PIX_W]) begin
               pix_cnt_d = pix_cnt_q + 10'd1;
               if (pix_cnt_q == ADDR_W'(BLOCK_WORDS - 1)) begin
                  state_d = ST_NEXT;
               end else begin
                  state_d = ST_PIX;
               end
            end else begin
               state_d = ST_PIX;
            end
         end
         ST_NEXT: state_d = ST_HOLD;
         ST_HOLD: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Landing read data and header words never coincide.
      push_valid_s = hdr_push_s || pend_q;
      push_word_s  = pend_q ? {1'b0, display_rddata} : {1'b1, hdr_data_s};
      // A read issued now lands next cycle; it needs a free slot then.
      room_s  = ({1'b0, free_s} + {2'b00, pop_s}) >= ({2'b00, push_valid_s} + 3'd1);
      issue_s = issue_win_s && !issue_cnt_q[ADDR_W] && room_s;
      issue_cnt_d = start_s ? '0 : (issue_cnt_q + {{ADDR_W{1'b0}}, issue_s});
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         hdr_idx_q   <= 2'd0;
         x0_q        <= 16'd0;
         y0_q        <= 16'd0;
         issue_cnt_q <= '0;
         pix_cnt_q   <= '0;
         pend_q      <= 1'b0;
         skip_q      <= 8'd0;
         next_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_idx_q   <= hdr_idx_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         issue_cnt_q <= issue_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         pend_q      <= issue_s;
         skip_q      <= skip_d;
         next_q      <= (state_d == ST_NEXT);
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   frameblock_skid #(
      .W(PIX_W + 1)
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (push_valid_s),
      .in_data_i  (push_word_s),
      .in_ready_o (skid_in_ready_s),
      .out_valid_o(skid_valid_s),
      .out_data_o (skid_out_s),
      .out_ready_i(out_ready),
      .free_o     (free_s)
   );

   assign display_rdaddr = issue_cnt_q[ADDR_W-1:0];
   assign display_next   = next_q;
   assign busy           = busy_q;
   assign skip_count     = skip_q;
   assign out_valid      = skid_valid_s;
   assign out_cmd        = skid_out_s[PIX_W];
   assign out_data       = skid_out_s[PIX_W-1:0];

endmodule

// File: tb/tb_frameblock_scanout.sv
// Directed/random bench for frameblock_scanout with a queue-based reference
// of the expected stream built from block-id arithmetic.
module tb_frameblock_scanout;

   localparam int BX = 10;
   localparam int BY = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] display_rddata = 16'd0;
   logic [9:0]  display_rdaddr;
   logic [6:0]  display_id = 7'd0;
   logic        display_ready = 1'b0;
   logic        display_next;
   logic [15:0] out_data;
   logic        out_cmd;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
   logic [7:0]  skip_count;

   int          n_asserts = 0;
   int          n_fail = 0;
   int          exp_skip = 0;
   logic [15:0] pat = 16'd0;

   frameblock_scanout #(.BLOCKS_X(BX), .BLOCKS_Y(BY)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .display_rddata(display_rddata),
      .display_rdaddr(display_rdaddr),
      .display_id    (display_id),
      .display_ready (display_ready),
      .display_next  (display_next),
      .out_data      (out_data),
      .out_cmd       (out_cmd),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .busy          (busy),
      .skip_count    (skip_count)
   );

   always #5 clk = ~clk;

   // Frameblock RAM: word n = n ^ pat, one cycle read latency.
   always @(posedge clk) display_rddata <= {6'd0, display_rdaddr} ^ pat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_data"}, {16'd0, out_data}, 32'd0);
      check({tag, "_cmd"}, {31'd0, out_cmd}, 32'd0);
      check({tag, "_next"}, {31'd0, display_next}, 32'd0);
      check({tag, "_addr"}, {22'd0, display_rdaddr}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_skip"}, {24'd0, skip_count}, 32'd0);
   endtask

   // Runs one block starting at the current negedge (cycle t = k 0).
   task automatic run_block(input int id, input int bp_pct, input bit hold_ready,
                            input int en_drop_pix, input int rst_pix);
      logic [16:0] expq[$];
      logic [16:0] w, prev;
      int k, k_next, n_next, n_hs, n_pix, k_hdr0, k_pix0, k_pixl, total;
      bit stalled, done, aborted, valid_id;
      valid_id = (id < BX * BY);
      if (valid_id) begin
         expq.push_back({1'b1, 16'((id % BX) * 32)});
         expq.push_back({1'b1, 16'((id % BX) * 32 + 31)});
         expq.push_back({1'b1, 16'((id / BX) * 32)});
         expq.push_back({1'b1, 16'((id / BX) * 32 + 31)});
         for (int n = 0; n < 1024; n++) expq.push_back({1'b0, 16'(n) ^ pat});
      end else begin
         exp_skip = (exp_skip + 1) % 256;
      end
      total = expq.size();
      k = 0; k_next = -1; n_next = 0; n_hs = 0; n_pix = 0;
      k_hdr0 = -1; k_pix0 = -1; k_pixl = -1;
      stalled = 1'b0; done = 1'b0; aborted = 1'b0; prev = '0;
      display_id = 7'(id);
      display_ready = 1'b1;
      enable = 1'b1;
      out_ready = ($urandom_range(99) >= bp_pct);
      while (!done) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            check("busy_t1", {31'd0, busy}, 32'd1);
            if (!valid_id) check("skip_count", {24'd0, skip_count}, exp_skip);
         end
         if (stalled) check("stall_hold", {14'd0, out_valid, out_cmd, out_data}, {14'd0, 1'b1, prev});
         if (display_next) begin
            n_next++;
            if (k_next < 0) begin
               k_next = k;
               check("hs_before_next", n_hs, total);
               if (bp_pct == 0) check("next_time", k, valid_id ? 1029 : 1);
            end
         end
         if (k_next > 0 && k > k_next) check("quiet_after_next", {31'd0, out_valid}, 32'd0);
         if (k_next > 0 && k == k_next + 2) begin
            check("idle_busy", {31'd0, busy}, 32'd0);
            done = 1'b1;
         end
         if (k_next > 0 && k == k_next + 1 && !hold_ready) display_ready = 1'b0;
         out_ready = ($urandom_range(99) >= bp_pct);
         if (!done && out_valid && out_ready) begin
            n_hs++;
            if (expq.size() == 0) begin
               check("extra_word", {15'd0, out_cmd, out_data}, 32'h1ffff);
            end else begin
               w = expq.pop_front();
               check("word", {15'd0, out_cmd, out_data}, {15'd0, w});
            end
            if (out_cmd) begin
               if (n_hs == 1) k_hdr0 = k;
            end else begin
               n_pix++;
               if (n_pix == 1) k_pix0 = k;
               if (n_pix == 1024) k_pixl = k;
               if (en_drop_pix > 0 && n_pix == en_drop_pix) enable = 1'b0;
               if (rst_pix > 0 && n_pix == rst_pix) begin
                  rst_n = 1'b0;
                  #1;
                  exp_skip = 0;
                  check_reset_outputs("mid_reset");
                  @(negedge clk);
                  check("reset_held_valid", {31'd0, out_valid}, 32'd0);
                  rst_n = 1'b1;
                  display_ready = 1'b0;
                  aborted = 1'b1;
                  done = 1'b1;
               end
            end
         end
         stalled = out_valid && !out_ready && !aborted;
         prev = {out_cmd, out_data};
         if (k >= 5000 && !done) begin
            check("timeout", k, 0);
            done = 1'b1;
         end
      end
      if (!aborted) begin
         check("next_pulses", n_next, 1);
         check("words_left", expq.size(), 0);
         if (valid_id && bp_pct == 0) begin
            check("hdr0_time", k_hdr0, 1);
            check("pix0_time", k_pix0, 5);
            check("pixlast_time", k_pixl, 1028);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      // Id 13, no backpressure, RAM word n = n.
      pat = 16'h0000;
      run_block(13, 0, 1'b0, 0, 0);

      // Same block with 50% random backpressure and a different RAM pattern.
      pat = 16'hA5C3;
      run_block(13, 50, 1'b0, 0, 0);

      // Random valid id with moderate backpressure.
      pat = 16'($urandom);
      run_block(int'($urandom_range(79)), 30, 1'b0, 0, 0);

      // Invalid ids: first 80, then enough random ones to wrap skip_count.
      run_block(80, 0, 1'b0, 0, 0);
      for (int i = 0; i < 255; i++) run_block(int'($urandom_range(127, 80)), 0, 1'b0, 0, 0);
      check("skip_wrap", {24'd0, skip_count}, 32'd0);

      // display_ready held high across two consecutive blocks.
      pat = 16'h0F0F;
      run_block(45, 0, 1'b1, 0, 0);
      run_block(79, 0, 1'b0, 0, 0);

      // enable dropped at pixel 500: block completes, no restart until enable.
      run_block(7, 20, 1'b0, 500, 0);
      display_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("no_start_valid", {31'd0, out_valid}, 32'd0);
         check("no_start_busy", {31'd0, busy}, 32'd0);
      end

      // Reset at pixel 300, then the block restarts from its header.
      pat = 16'h1234;
      run_block(22, 0, 1'b0, 0, 300);
      run_block(22, 0, 1'b0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
